// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: credit-limited word fetches into a DEPTH-entry queue, realigned into
// one raw 16/32-bit instruction per cycle for decode; redirects squash everything still in flight.
`ifndef PMEM_START
`define PMEM_START 64'h0000_0000_8000_0000
`endif

module ifetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(`PMEM_START)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] exception_newPC_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            mem_req_valid_o,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_req_ready_i,
  input  logic            mem_resp_valid_i,
  input  logic [31:0]     mem_resp_data_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o,
  output logic            is_compressed_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] fpc, dpc;
  logic [31:0]     q [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, inflight, drop_cnt, inflight_nxt;
  logic            lo_valid, skip_half;
  logic [15:0]     lo;

  logic            redirect, req_fire, resp_push, has_word;
  logic [XLEN-1:0] target;
  logic [31:0]     head_word, inst_raw;
  logic            avail, comp, skip_step, cons_pop, cons_lo;
  logic            consume, skip_fire, pop;

  assign redirect = reset | exception_i | branch_i;
  assign target   = reset       ? RESET_PC :
                    exception_i ? exception_newPC_i : branch_target_i;

  assign mem_req_valid_o = !reset && ((count + inflight) < DEPTH_C);
  assign mem_req_addr_o  = fpc;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;

  // Reset is handled as a redirect: the memory side keeps answering requests
  // issued before reset, so the outstanding count is carried into drop_cnt.
  assign inflight_nxt = inflight + CW'(req_fire) - CW'(mem_resp_valid_i && (inflight != '0));
  assign resp_push    = mem_resp_valid_i && (drop_cnt == '0) && !redirect;

  assign has_word  = (count != '0);
  assign head_word = q[head];

  always_comb begin
    avail     = 1'b0;
    comp      = 1'b0;
    skip_step = 1'b0;
    cons_pop  = 1'b0;
    cons_lo   = 1'b0;
    inst_raw  = '0;
    if (skip_half && has_word) begin
      skip_step = 1'b1;
    end else if (lo_valid && lo[1:0] != 2'b11) begin
      avail    = 1'b1;
      comp     = 1'b1;
      inst_raw = {16'h0000, lo};
    end else if (lo_valid && has_word) begin
      // 32-bit instruction straddling the word boundary
      avail    = 1'b1;
      inst_raw = {head_word[15:0], lo};
      cons_pop = 1'b1;
      cons_lo  = 1'b1;
    end else if (!lo_valid && has_word && head_word[1:0] != 2'b11) begin
      avail    = 1'b1;
      comp     = 1'b1;
      inst_raw = {16'h0000, head_word[15:0]};
      cons_pop = 1'b1;
      cons_lo  = 1'b1;
    end else if (!lo_valid && has_word) begin
      avail    = 1'b1;
      inst_raw = head_word;
      cons_pop = 1'b1;
    end
  end

  assign inst_valid_o    = avail && !reset;
  assign inst_o          = inst_valid_o ? inst_raw : 32'h0;
  assign is_compressed_o = inst_valid_o && comp;
  assign pc_o            = reset ? RESET_PC : dpc;

  assign consume   = inst_valid_o && !stall_i && !redirect;
  assign skip_fire = skip_step && !stall_i && !redirect;
  assign pop       = (consume && cons_pop) || skip_fire;

  always_ff @(posedge clock) begin
    if (resp_push) begin
      q[tail] <= mem_resp_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (redirect) begin
      fpc       <= {target[XLEN-1:2], 2'b00};
      dpc       <= target;
      skip_half <= target[1];
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      lo_valid  <= 1'b0;
      inflight  <= inflight_nxt;
      drop_cnt  <= inflight_nxt;
    end else begin
      inflight <= inflight_nxt;
      if (req_fire) begin
        fpc <= fpc + XLEN'(4);
      end
      if (mem_resp_valid_i && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (resp_push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(resp_push) - CW'(pop);
      if (consume) begin
        dpc      <= dpc + (comp ? XLEN'(2) : XLEN'(4));
        lo_valid <= cons_lo;
        if (cons_lo) begin
          lo <= head_word[31:16];
        end
      end else if (skip_fire) begin
        lo        <= head_word[31:16];
        lo_valid  <= 1'b1;
        skip_half <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: scripted in-order memory with adjustable latency
// and straight-line checks of hand-derived fetch/realign/redirect behaviour.
`timescale 1ns/1ps
module tb_ifetch_queue;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        exception_i = 1'b0;
  logic [63:0] exception_newPC_i = '0;
  logic        branch_i = 1'b0;
  logic [63:0] branch_target_i = '0;
  logic        mem_req_valid_o;
  logic [63:0] mem_req_addr_o;
  logic        mem_req_ready_i = 1'b1;
  logic        mem_resp_valid_i = 1'b0;
  logic [31:0] mem_resp_data_i = '0;
  logic        inst_valid_o;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic        is_compressed_o;

  int vectors = 0;
  int miscompares = 0;
  int mem_lat = 1;
  int cyc = 0;
  logic [31:0] rq_data[$];
  int          rq_due[$];

  always #5 clock = ~clock;

  ifetch_queue #(.XLEN(64), .DEPTH(4), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .stall_i(stall_i),
    .exception_i(exception_i), .exception_newPC_i(exception_newPC_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .inst_valid_o(inst_valid_o), .pc_o(pc_o),
    .inst_o(inst_o), .is_compressed_o(is_compressed_o)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0000_0000: return 32'h0001_0001;
      64'h0000_0010: return 32'h0013_0001;
      64'h0000_0014: return 32'h0001_0000;
      64'h8000_0000: return 32'h00A0_0093;
      64'h8000_0100: return 32'h4501_0013;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // In-order memory: a request accepted at edge k answers in cycle k+mem_lat-1.
  always @(posedge clock) begin
    if (mem_resp_valid_i) begin
      void'(rq_data.pop_front());
      void'(rq_due.pop_front());
    end
    cyc = cyc + 1;
    if (mem_req_valid_o && mem_req_ready_i) begin
      rq_data.push_back(mem_word(mem_req_addr_o));
      rq_due.push_back(cyc + mem_lat - 1);
    end
    #1;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = rq_data[0];
    end else begin
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input string tag, input logic [63:0] pc,
                            input logic [31:0] inst, input logic comp);
    check({tag, "_vld"}, inst_valid_o, 1);
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_inst"}, inst_o, inst);
    check({tag, "_comp"}, is_compressed_o, comp);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (inst_valid_o !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, inst_valid_o, 1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_vld", inst_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_comp", is_compressed_o, 0);
    check("rst_req", mem_req_valid_o, 0);
    check("rst_pc", pc_o, RPC);
    tick();
    reset = 1'b0;
    #1;
    check("first_req_vld", mem_req_valid_o, 1);
    check("first_req_addr", mem_req_addr_o, RPC);
    tick();
    check("boot_empty", inst_valid_o, 0);
    tick();
    check_inst("boot0", RPC, 32'h00A0_0093, 1'b0);
    check("boot_req_addr", mem_req_addr_o, RPC + 64'h8);
    tick();
    check_inst("boot1", RPC + 64'h4, 32'h0000_0013, 1'b0);
    tick();
    check_inst("boot2", RPC + 64'h8, 32'h0000_0013, 1'b0);

    // two c.nop in one word, then a 32-bit word
    branch_i = 1'b1; branch_target_i = 64'h0;
    tick();
    branch_i = 1'b0;
    check("br0_vld", inst_valid_o, 0);
    check("br0_req_addr", mem_req_addr_o, 64'h0);
    tick();
    check("br0_wait", inst_valid_o, 0);
    tick();
    check_inst("cnop0", 64'h0, 32'h0000_0001, 1'b1);
    tick();
    check_inst("cnop1", 64'h2, 32'h0000_0001, 1'b1);
    tick();
    check_inst("after_cnop", 64'h4, 32'h0000_0013, 1'b0);

    // straddling 32-bit instruction followed by a compressed one without a bubble
    branch_i = 1'b1; branch_target_i = 64'h10;
    tick();
    branch_i = 1'b0;
    check("br1_req_addr", mem_req_addr_o, 64'h10);
    tick();
    check("br1_wait", inst_valid_o, 0);
    tick();
    check_inst("str_c0", 64'h10, 32'h0000_0001, 1'b1);
    tick();
    check_inst("str_32", 64'h12, 32'h0000_0013, 1'b0);
    tick();
    check_inst("str_c1", 64'h16, 32'h0000_0001, 1'b1);
    tick();
    check_inst("str_next", 64'h18, 32'h0000_0013, 1'b0);

    // latency 3: redirect to a halfword target with three requests in flight
    branch_i = 1'b1; branch_target_i = RPC + 64'h200;
    tick();
    branch_i = 1'b0;
    mem_lat = 3;
    tick();
    tick();
    tick();
    branch_i = 1'b1; branch_target_i = RPC + 64'h102;
    tick();
    branch_i = 1'b0;
    check("lat_vld", inst_valid_o, 0);
    check("lat_req_addr", mem_req_addr_o, RPC + 64'h100);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lat_squash", inst_valid_o, 0);
    end
    tick();
    check_inst("lat_hi", RPC + 64'h102, 32'h0000_4501, 1'b1);
    tick();
    check_inst("lat_next", RPC + 64'h104, 32'h0000_0013, 1'b0);

    // exception wins over a simultaneous branch
    exception_i = 1'b1; exception_newPC_i = 64'h0;
    branch_i = 1'b1; branch_target_i = 64'h10;
    tick();
    exception_i = 1'b0; branch_i = 1'b0;
    check("exc_req_addr", mem_req_addr_o, 64'h0);
    wait_valid("exc_timeout", 30);
    check_inst("exc", 64'h0, 32'h0000_0001, 1'b1);

    // stall freezes the output while fetching fills the queue
    stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_pc", pc_o, 64'h0);
      check("stall_inst", inst_o, 32'h0000_0001);
    end
    check("stall_full", mem_req_valid_o, 0);
    stall_i = 1'b0;
    tick();
    check_inst("unstall0", 64'h2, 32'h0000_0001, 1'b1);
    tick();
    check_inst("unstall1", 64'h4, 32'h0000_0013, 1'b0);

    // reset mid-stream with responses still outstanding
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mrst_vld", inst_valid_o, 0);
    check("mrst_inst", inst_o, 0);
    check("mrst_req", mem_req_valid_o, 0);
    check("mrst_pc", pc_o, RPC);
    tick();
    check("mrst_vld2", inst_valid_o, 0);
    tick();
    reset = 1'b0;
    #1;
    check("mrst_req_addr", mem_req_addr_o, RPC);
    wait_valid("mrst_timeout0", 30);
    check_inst("mrst0", RPC, 32'h00A0_0093, 1'b0);
    tick();
    wait_valid("mrst_timeout1", 30);
    check_inst("mrst1", RPC + 64'h4, 32'h0000_0013, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
